reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Synchronous system reset and watchdog controller, clocked from CLK_24M.
- Arbitrates four reset sources onto the 68k nRESET/nHALT pair and a separate peripheral reset:
  - power-on (nRST)
  - debounced front-panel button
  - watchdog timeout, counted in frames
  - 68k RESET instruction
- Sits between the address decoder (kick strobe), LSPC (frame strobe) and the 68k reset pins.

Parameters:
- WD_TIMEOUT_FRAMES, 8: FRAME_TICKs without a kick before a watchdog reset fires (legal range 1..255).
- RESET_HOLD_FRAMES, 8: FRAME_TICKs that nRESET/nHALT stay low after a button or watchdog reset (legal range 1..255).
- POR_CYCLES, 32: CLK_24M cycles of reset hold after nRST deasserts.
- DEBOUNCE_CYCLES, 4096: consecutive stable cycles required to accept a change in the button level.

Ports:
- CLK_24M  in  1  system clock.
- nRST  in  1  asynchronous, active-low reset.
- FRAME_TICK  in  1  one-cycle strobe, once per frame.
- WDKICK  in  1  one-cycle strobe from the decoder on a 68k write to 0x300001.
- nCPU_RESET_IN  in  1  asynchronous; low while the 68k executes a RESET instruction.
- nBTN_RESET  in  1  raw front-panel button, asynchronous, bouncy, active-low.
- nRESET  out  1  68k reset, active-low.
- nHALT  out  1  68k halt, active-low.
- nPERIPH_RST  out  1  peripheral reset, active-low.
- RESET_CAUSE  out  2  cause of the last reset: 0 = POR, 1 = button, 2 = watchdog, 3 = reserved.
- WD_COUNT  out  8  current watchdog frame count (debug).

Behaviour:
- Reset and outputs
  - Reset is asynchronous, active-low.
  - While nRST is low: state = POR, nRESET = nHALT = nPERIPH_RST = 0, RESET_CAUSE = 0, all counters = 0.
  - All outputs are registered. Each output reflects an event one cycle after the CLK_24M edge that samples it.
- Input synchronisation
  - nBTN_RESET and nCPU_RESET_IN each pass through a 2-flop synchroniser.
  - The button then passes through the debouncer. The debounced level changes only after DEBOUNCE_CYCLES identical consecutive synchronised samples; any differing sample restarts the count.
- FSM states: POR, HOLD, RUN.
  - POR
    - Outputs low.
    - Cycle counter runs; after POR_CYCLES cycles -> RUN.
    - RESET_CAUSE stays 0.
  - RUN
    - nRESET = nHALT = 1.
    - nPERIPH_RST = synchronised nCPU_RESET_IN.
    - Watchdog counter:
      - WDKICK -> 0.
      - Else FRAME_TICK -> +1.
      - WDKICK and FRAME_TICK in the same cycle: the kick wins, counter = 0.
      - Synchronised nCPU_RESET_IN low -> counter held at 0 (the watchdog is a peripheral).
    - Counter reaching WD_TIMEOUT_FRAMES -> HOLD, cause = 2, counter cleared.
    - Debounced button falling edge -> HOLD, cause = 1.
  - HOLD
    - nRESET = nHALT = nPERIPH_RST = 0.
    - Hold counter increments on FRAME_TICK.
    - Exit -> RUN only when the hold counter reaches RESET_HOLD_FRAMES and the debounced button is released. While the button is held, the hold counter saturates and the state stays HOLD.
    - Button press during a watchdog HOLD: cause becomes 1 and the hold counter restarts at 0.
    - WDKICK is ignored in HOLD.
- Priority, same cycle: POR > button > watchdog > CPU RESET instruction.
- Entering RUN clears the watchdog counter.
- WD_COUNT is the live watchdog counter in RUN and 0 in POR/HOLD.
- Counters saturate and never wrap.
- nRST asserted mid-operation aborts any state immediately, asynchronously, into POR.

Optional Feature:
- Macro: RESET_SEQ_WD_FREEZE_EN.
- Defined:
  - Adds input port WD_FREEZE (1 bit, synchronous).
  - While WD_FREEZE = 1 in RUN, FRAME_TICK does not advance the watchdog counter.
  - WDKICK still clears the counter.
  - Used for debug and attract-mode capture.
- Undefined: the port is absent and the watchdog always counts.

Decomposition:
- Package reset_seq_pkg holds:
  - the state enum (POR, HOLD, RUN)
  - cause codes (CAUSE_POR, CAUSE_BTN, CAUSE_WD)
  - the 8-bit frame counter width constant
- One sub-module, reset_debounce: 2-flop synchroniser plus stable-count debouncer, parameterised by DEBOUNCE_CYCLES. Outputs the debounced level and a one-cycle falling-edge pulse.
- nCPU_RESET_IN uses the synchroniser inline.

Test Plan:
1. Power-on:
   - Stimulus: release nRST at cycle 0.
   - Response: nRESET/nHALT/nPERIPH_RST low through cycle 32, high at cycle 33, RESET_CAUSE = 0.
2. Watchdog timeout:
   - Stimulus: in RUN, 8 FRAME_TICKs with no kick.
   - Response: nRESET/nHALT low one cycle after the 8th tick, RESET_CAUSE = 2. Back high one cycle after the 8th subsequent tick. WD_COUNT reads 0 after release.
3. Kick/tick collision:
   - Stimulus: 7 ticks, then WDKICK and FRAME_TICK in the same cycle, then 7 more ticks.
   - Response: no reset; WD_COUNT = 7.
4. Button bounce:
   - Stimulus: nBTN_RESET toggles every 100 cycles for 2000 cycles, then stays low.
   - Response: HOLD entered 4096 + 2–3 cycles after the last edge, cause = 1. HOLD persists while the button is held beyond 8 frames and exits once the button has been released and debounced.
5. CPU RESET instruction:
   - Stimulus: nCPU_RESET_IN low for 124 cycles while WD_COUNT = 5.
   - Response: nPERIPH_RST low for 124 cycles (2-cycle delay), nRESET stays high, WD_COUNT = 0.
6. Mid-HOLD reset:
   - Stimulus: assert nRST during a watchdog HOLD.
   - Response: immediate POR, RESET_CAUSE = 0. With RESET_SEQ_WD_FREEZE_EN and WD_FREEZE = 1, 20 ticks produce no reset.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, reset cause codes
// and the frame counter width.
package reset_seq_pkg;

    localparam int FRAME_W = 8;

    typedef enum logic [1:0] {
        ST_POR  = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_BTN = 2'd1;
    localparam logic [1:0] CAUSE_WD  = 2'd2;

endpackage

// File: rtl/reset_debounce.sv
// Front-panel button conditioner: 2-flop synchroniser followed by a stable-count debouncer.
// Produces the debounced level and a one-cycle pulse on the debounced falling edge.
module reset_debounce #(
    parameter int DEBOUNCE_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_fall
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_done;

    // Counting runs only while the synchronised sample disagrees with the accepted level;
    // a single agreeing sample drops the count back to zero.
    assign w_diff = (r_s2 != r_db);
    assign w_done = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1  <= 1'b1;
            r_s2  <= 1'b1;
            r_db  <= 1'b1;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_btn_n;
            r_s2 <= r_s1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_cnt <= '0;
                r_db  <= r_s2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_db;
    assign o_fall  = w_done && !r_s2;

endmodule

// File: rtl/reset_sequencer.sv
// System reset and watchdog controller: arbitrates POR, button, watchdog and 68k RESET
// onto nRESET/nHALT and nPERIPH_RST. Optional WD_FREEZE port under RESET_SEQ_WD_FREEZE_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int WD_TIMEOUT_FRAMES = 8,
    parameter int RESET_HOLD_FRAMES = 8,
    parameter int POR_CYCLES        = 32,
    parameter int DEBOUNCE_CYCLES   = 4096
) (
    input  logic               CLK_24M,
    input  logic               nRST,
    input  logic               FRAME_TICK,
    input  logic               WDKICK,
`ifdef RESET_SEQ_WD_FREEZE_EN
    input  logic               WD_FREEZE,
`endif
    input  logic               nCPU_RESET_IN,
    input  logic               nBTN_RESET,
    output logic               nRESET,
    output logic               nHALT,
    output logic               nPERIPH_RST,
    output logic [1:0]         RESET_CAUSE,
    output logic [FRAME_W-1:0] WD_COUNT
);
    localparam int                 POR_W    = $clog2(POR_CYCLES + 1);
    localparam logic [FRAME_W-1:0] WD_LIM   = FRAME_W'(WD_TIMEOUT_FRAMES);
    localparam logic [FRAME_W-1:0] HOLD_LIM = FRAME_W'(RESET_HOLD_FRAMES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [POR_W-1:0]   r_por_cnt;
    logic [POR_W-1:0]   w_por_nxt;
    logic [FRAME_W-1:0] r_wd_cnt;
    logic [FRAME_W-1:0] w_wd_nxt;
    logic [FRAME_W-1:0] w_wd_tmp;
    logic [FRAME_W-1:0] r_hold_cnt;
    logic [FRAME_W-1:0] w_hold_nxt;
    logic [FRAME_W-1:0] w_hold_tmp;
    logic [1:0]         r_cause;
    logic [1:0]         w_cause_nxt;
    logic               r_cpu_s1;
    logic               r_cpu_s2;
    logic               r_nreset;
    logic               r_nhalt;
    logic               r_nperiph;
    logic               w_btn_db;
    logic               w_btn_fall;
    logic               w_freeze;
    logic               w_run_nxt;

`ifdef RESET_SEQ_WD_FREEZE_EN
    assign w_freeze = WD_FREEZE;
`else
    assign w_freeze = 1'b0;
`endif

    reset_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (CLK_24M),
        .rst_n   (nRST),
        .i_btn_n (nBTN_RESET),
        .o_level (w_btn_db),
        .o_fall  (w_btn_fall)
    );

    always_ff @(posedge CLK_24M or negedge nRST) begin
        if (!nRST) begin
            r_cpu_s1 <= 1'b1;
            r_cpu_s2 <= 1'b1;
        end else begin
            r_cpu_s1 <= nCPU_RESET_IN;
            r_cpu_s2 <= r_cpu_s1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_por_nxt   = r_por_cnt;
        w_wd_nxt    = r_wd_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_cause_nxt = r_cause;
        w_wd_tmp    = r_wd_cnt;
        w_hold_tmp  = r_hold_cnt;
        case (r_state)
            ST_POR: begin
                w_wd_nxt    = '0;
                w_hold_nxt  = '0;
                w_cause_nxt = CAUSE_POR;
                if (r_por_cnt == POR_W'(POR_CYCLES)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_por_nxt = r_por_cnt + POR_W'(1);
                end
            end
            ST_RUN: begin
                // Kick beats a same-cycle tick; a CPU RESET instruction pins the count at zero.
                if (!r_cpu_s2 || WDKICK) begin
                    w_wd_tmp = '0;
                end else if (FRAME_TICK && !w_freeze && (r_wd_cnt != '1)) begin
                    w_wd_tmp = r_wd_cnt + FRAME_W'(1);
                end
                if (w_btn_fall) begin
                    w_state_nxt = ST_HOLD;
                    w_cause_nxt = CAUSE_BTN;
                    w_hold_nxt  = '0;
                    w_wd_nxt    = '0;
                end else if (w_wd_tmp >= WD_LIM) begin
                    w_state_nxt = ST_HOLD;
                    w_cause_nxt = CAUSE_WD;
                    w_hold_nxt  = '0;
                    w_wd_nxt    = '0;
                end else begin
                    w_wd_nxt = w_wd_tmp;
                end
            end
            ST_HOLD: begin
                w_wd_nxt = '0;
                if (w_btn_fall) begin
                    w_cause_nxt = CAUSE_BTN;
                    w_hold_nxt  = '0;
                end else begin
                    if (FRAME_TICK && (r_hold_cnt < HOLD_LIM)) begin
                        w_hold_tmp = r_hold_cnt + FRAME_W'(1);
                    end
                    // Held button keeps us here with the hold count parked at its limit.
                    if ((w_hold_tmp >= HOLD_LIM) && w_btn_db) begin
                        w_state_nxt = ST_RUN;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = w_hold_tmp;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_POR;
                w_por_nxt   = '0;
                w_wd_nxt    = '0;
                w_hold_nxt  = '0;
                w_cause_nxt = CAUSE_POR;
            end
        endcase
    end

    assign w_run_nxt = (w_state_nxt == ST_RUN);

    always_ff @(posedge CLK_24M or negedge nRST) begin
        if (!nRST) begin
            r_state    <= ST_POR;
            r_por_cnt  <= '0;
            r_wd_cnt   <= '0;
            r_hold_cnt <= '0;
            r_cause    <= CAUSE_POR;
            r_nreset   <= 1'b0;
            r_nhalt    <= 1'b0;
            r_nperiph  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_por_cnt  <= w_por_nxt;
            r_wd_cnt   <= w_wd_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_cause    <= w_cause_nxt;
            r_nreset   <= w_run_nxt;
            r_nhalt    <= w_run_nxt;
            // Fed from the first sync stage so this register doubles as the second one.
            r_nperiph  <= w_run_nxt && r_cpu_s1;
        end
    end

    assign nRESET      = r_nreset;
    assign nHALT       = r_nhalt;
    assign nPERIPH_RST = r_nperiph;
    assign RESET_CAUSE = r_cause;
    assign WD_COUNT    = r_wd_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus schedules expected outputs by cycle,
// a negedge monitor pops and compares them.
module tb_reset_sequencer;

    logic       CLK_24M = 1'b0;
    logic       nRST = 1'b0;
    logic       FRAME_TICK = 1'b0;
    logic       WDKICK = 1'b0;
    logic       WD_FREEZE = 1'b0;
    logic       nCPU_RESET_IN = 1'b1;
    logic       nBTN_RESET = 1'b1;
    logic       nRESET;
    logic       nHALT;
    logic       nPERIPH_RST;
    logic [1:0] RESET_CAUSE;
    logic [7:0] WD_COUNT;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic       nres;
        logic       nper;
        logic [1:0] cause;
        logic [7:0] wd;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    reset_sequencer dut (
        .CLK_24M       (CLK_24M),
        .nRST          (nRST),
        .FRAME_TICK    (FRAME_TICK),
        .WDKICK        (WDKICK),
`ifdef RESET_SEQ_WD_FREEZE_EN
        .WD_FREEZE     (WD_FREEZE),
`endif
        .nCPU_RESET_IN (nCPU_RESET_IN),
        .nBTN_RESET    (nBTN_RESET),
        .nRESET        (nRESET),
        .nHALT         (nHALT),
        .nPERIPH_RST   (nPERIPH_RST),
        .RESET_CAUSE   (RESET_CAUSE),
        .WD_COUNT      (WD_COUNT)
    );

    always #5 CLK_24M = ~CLK_24M;
    always @(posedge CLK_24M) cyc <= cyc + 1;

    function automatic void expect_at(int c, logic nres, logic nper, logic [1:0] cause,
                                      logic [7:0] wd, string name);
        exp_t e;
        int   idx;
        e.cyc = c; e.nres = nres; e.nper = nper; e.cause = cause; e.wd = wd; e.name = name;
        idx = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        exp_q.insert(idx, e);
    endfunction

    always @(negedge CLK_24M) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (mon_e.cyc < cyc || nRESET !== mon_e.nres || nHALT !== mon_e.nres ||
                nPERIPH_RST !== mon_e.nper || RESET_CAUSE !== mon_e.cause ||
                WD_COUNT !== mon_e.wd) begin
                failures++;
                $display("FAIL %s cyc=%0d/%0d got nRESET=%b nHALT=%b nPERIPH=%b cause=%0d wd=%0d exp nRESET=nHALT=%b nPERIPH=%b cause=%0d wd=%0d",
                         mon_e.name, cyc, mon_e.cyc, nRESET, nHALT, nPERIPH_RST, RESET_CAUSE,
                         WD_COUNT, mon_e.nres, mon_e.nper, mon_e.cause, mon_e.wd);
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge CLK_24M);
            #1;
        end
    endtask

    task automatic tick_pulse();
        FRAME_TICK = 1'b1;
        step(1);
        FRAME_TICK = 1'b0;
    endtask

    task automatic kick_pulse();
        WDKICK = 1'b1;
        step(1);
        WDKICK = 1'b0;
    endtask

    task automatic do_por();
        int c0;
        nRST = 1'b1;
        c0 = cyc;
        expect_at(c0 + 1, 1'b0, 1'b0, 2'd0, 8'd0, "por_first");
        expect_at(c0 + 32, 1'b0, 1'b0, 2'd0, 8'd0, "por_low_32");
        expect_at(c0 + 33, 1'b1, 1'b1, 2'd0, 8'd0, "por_high_33");
        step(36);
    endtask

    task automatic wd_fire(logic [1:0] cause_before);
        for (int i = 1; i <= 8; i++) begin
            tick_pulse();
            if (i < 8) expect_at(cyc, 1'b1, 1'b1, cause_before, 8'(i), "wd_count");
            else       expect_at(cyc, 1'b0, 1'b0, 2'd2, 8'd0, "wd_fire");
            step(1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d pending=%0d", cyc, exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        step(3);
        expect_at(cyc, 1'b0, 1'b0, 2'd0, 8'd0, "reset_state");
        step(1);

        // Power-on sequence
        do_por();

        // Watchdog timeout, kick ignored in HOLD, release after 8 ticks
        wd_fire(2'd0);
        kick_pulse();
        expect_at(cyc, 1'b0, 1'b0, 2'd2, 8'd0, "hold_kick_ignored");
        for (int i = 1; i <= 8; i++) begin
            tick_pulse();
            if (i < 8) expect_at(cyc, 1'b0, 1'b0, 2'd2, 8'd0, "hold_wait");
            else       expect_at(cyc, 1'b1, 1'b1, 2'd2, 8'd0, "hold_exit");
            step(2);
        end
        expect_at(cyc, 1'b1, 1'b1, 2'd2, 8'd0, "wd_zero_after");

        // Kick/tick collision
        for (int i = 1; i <= 7; i++) begin
            tick_pulse();
            expect_at(cyc, 1'b1, 1'b1, 2'd2, 8'(i), "pre_collide");
        end
        FRAME_TICK = 1'b1;
        WDKICK = 1'b1;
        step(1);
        FRAME_TICK = 1'b0;
        WDKICK = 1'b0;
        expect_at(cyc, 1'b1, 1'b1, 2'd2, 8'd0, "collide_kick_wins");
        for (int i = 1; i <= 7; i++) begin
            tick_pulse();
        end
        expect_at(cyc, 1'b1, 1'b1, 2'd2, 8'd7, "collide_end");
        step(1);
        kick_pulse();
        expect_at(cyc, 1'b1, 1'b1, 2'd2, 8'd0, "kick_clear");
        for (int i = 1; i <= 5; i++) tick_pulse();
        expect_at(cyc, 1'b1, 1'b1, 2'd2, 8'd5, "wd_five");
        step(1);

        // CPU RESET instruction
        nCPU_RESET_IN = 1'b0;
        c = cyc;
        expect_at(c + 1, 1'b1, 1'b1, 2'd2, 8'd5, "cpu_pre");
        expect_at(c + 2, 1'b1, 1'b0, 2'd2, 8'd5, "cpu_periph_low");
        expect_at(c + 3, 1'b1, 1'b0, 2'd2, 8'd0, "cpu_wd_clear");
        expect_at(c + 124, 1'b1, 1'b0, 2'd2, 8'd0, "cpu_mid");
        step(124);
        nCPU_RESET_IN = 1'b1;
        expect_at(c + 125, 1'b1, 1'b0, 2'd2, 8'd0, "cpu_last_low");
        expect_at(c + 126, 1'b1, 1'b1, 2'd2, 8'd0, "cpu_periph_high");
        step(5);

        // Button bounce then hold
        for (int k = 0; k < 20; k++) begin
            nBTN_RESET = k[0];
            step(100);
        end
        expect_at(cyc, 1'b1, 1'b1, 2'd2, 8'd0, "bounce_no_reset");
        nBTN_RESET = 1'b0;
        c = cyc;
        expect_at(c + 4097, 1'b1, 1'b1, 2'd2, 8'd0, "btn_pre");
        expect_at(c + 4098, 1'b0, 1'b0, 2'd1, 8'd0, "btn_hold");
        step(4100);
        for (int i = 1; i <= 10; i++) begin
            tick_pulse();
            if (i == 8 || i == 10) expect_at(cyc, 1'b0, 1'b0, 2'd1, 8'd0, "btn_held");
            step(1);
        end
        nBTN_RESET = 1'b1;
        c = cyc;
        expect_at(c + 4098, 1'b0, 1'b0, 2'd1, 8'd0, "rel_pre");
        expect_at(c + 4099, 1'b1, 1'b1, 2'd1, 8'd0, "rel_exit");
        step(4102);

        // Mid-HOLD asynchronous reset
        wd_fire(2'd1);
        for (int i = 0; i < 3; i++) tick_pulse();
        nRST = 1'b0;
        expect_at(cyc, 1'b0, 1'b0, 2'd0, 8'd0, "async_por");
        step(3);
        expect_at(cyc, 1'b0, 1'b0, 2'd0, 8'd0, "por_held");
        step(1);
        do_por();

`ifdef RESET_SEQ_WD_FREEZE_EN
        for (int i = 0; i < 3; i++) tick_pulse();
        expect_at(cyc, 1'b1, 1'b1, 2'd0, 8'd3, "prefreeze");
        WD_FREEZE = 1'b1;
        for (int i = 0; i < 20; i++) tick_pulse();
        expect_at(cyc, 1'b1, 1'b1, 2'd0, 8'd3, "freeze_ticks");
        kick_pulse();
        expect_at(cyc, 1'b1, 1'b1, 2'd0, 8'd0, "freeze_kick");
        for (int i = 0; i < 20; i++) tick_pulse();
        expect_at(cyc, 1'b1, 1'b1, 2'd0, 8'd0, "freeze_no_reset");
        WD_FREEZE = 1'b0;
`endif

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1);
        if (exp_q.size() > 0) begin
            $display("FAIL pending_checks got=%0d required=0", exp_q.size());
            failures += exp_q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
